mod_reg16_ser: RTL and testbench

- Upstream neighbour of the one-byte ROM-feed FIFO in the S-box path.
- Accepts a 128-bit AES state word in one cycle and serializes it into 16 bytes.
- Presents one byte at a time to the FIFO, and advances only when the FIFO signals it is empty.
- Its empty flag is the FIFO's "source empty" input; the FIFO captures a byte on any edge where FIFO empty=1 and this block's empty=0.

---
 rtl/aes_pkg.sv | 15 +
 rtl/mod_reg16_ser_if.sv | 30 +++
 rtl/mod_reg16_ser.sv | 108 ++++++++++
 tb/tb_mod_reg16_ser.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath types used by the S-box feed path.
package aes_pkg;

    localparam int AES_NBYTES = 16;
    localparam int AES_BYTE_W = 8;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/mod_reg16_ser_if.sv
// Load-side and FIFO-side signals of the state-word serializer.
interface mod_reg16_ser_if
    import aes_pkg::*;
#(
    parameter int NBYTES = AES_NBYTES,
    parameter int BYTE_W = AES_BYTE_W
);

    logic [NBYTES*BYTE_W-1:0]  inp;
    logic                      load;
    logic                      fifo_empty;
    logic [BYTE_W-1:0]         outp;
    logic                      empty;
    logic                      ready_in;
    logic                      last;
    logic [$clog2(NBYTES)-1:0] byte_idx;
    logic                      load_err;

    // master is the serializer itself; slave is whatever loads it and drains it
    modport master (
        input  inp, load, fifo_empty,
        output outp, empty, ready_in, last, byte_idx, load_err
    );

    modport slave (
        output inp, load, fifo_empty,
        input  outp, empty, ready_in, last, byte_idx, load_err
    );

endinterface

// File: rtl/mod_reg16_ser.sv
// Splits a loaded AES state word into bytes and hands them one at a time
// to the one-byte ROM-feed FIFO, advancing only when that FIFO is empty.
module mod_reg16_ser
    import aes_pkg::*;
#(
    parameter int NBYTES    = AES_NBYTES,
    parameter int BYTE_W    = AES_BYTE_W,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            reset,
    mod_reg16_ser_if.master bus
);

    localparam int W  = NBYTES * BYTE_W;
    localparam int IW = $clog2(NBYTES);

    typedef logic [IW-1:0] idx_t;

    ser_state_t        state_q, state_d;
    logic [W-1:0]      shreg_q, shreg_d;
    logic [BYTE_W-1:0] outp_q, outp_d;
    logic              last_q, last_d;
    idx_t              idx_q, idx_d;
    logic              load_err_q, load_err_d;
    logic              xfer;
    logic [W-1:0]      shifted;
    idx_t              next_idx;

    // The byte being offered always sits at the head of the shift register
    function automatic logic [BYTE_W-1:0] head_byte(input logic [W-1:0] v);
        if (MSB_FIRST != 0) return v[W-1 -: BYTE_W];
        else                return v[BYTE_W-1:0];
    endfunction

    function automatic logic [W-1:0] drop_head(input logic [W-1:0] v);
        if (MSB_FIRST != 0) return v << BYTE_W;
        else                return v >> BYTE_W;
    endfunction

    assign xfer = (state_q == SHIFT) && bus.fifo_empty;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        outp_d     = outp_q;
        last_d     = last_q;
        idx_d      = idx_q;
        load_err_d = 1'b0;
        shifted    = drop_head(shreg_q);
        next_idx   = idx_q + idx_t'(1);

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shreg_d = bus.inp;
                    outp_d  = head_byte(bus.inp);
                    idx_d   = '0;
                    last_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A load here is dropped, even on the edge that finishes the word
                load_err_d = bus.load;
                if (xfer) begin
                    if (last_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        shreg_d = shifted;
                        outp_d  = head_byte(shifted);
                        idx_d   = next_idx;
                        last_d  = (next_idx == idx_t'(NBYTES - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            outp_q     <= '0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            outp_q     <= outp_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.outp     = outp_q;
    assign bus.empty    = (state_q == IDLE);
    assign bus.ready_in = (state_q == IDLE);
    assign bus.last     = last_q;
    assign bus.byte_idx = idx_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_mod_reg16_ser.sv
// Scoreboard bench for mod_reg16_ser: one MSB-first and one LSB-first instance
// share the stimulus, with a one-byte FIFO model draining whichever is observed.
module tb_mod_reg16_ser;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [3:0] idx;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [127:0] inp;
    logic         load;
    logic         fifo_empty;
    logic         sel;

    int   compare_count  = 0;
    int   mismatch_count = 0;
    exp_t sb[$];

    int   rd_period    = 0;
    int   cyc          = 0;
    bit   fifo_full    = 1'b0;
    bit   xfer_pending = 1'b0;
    bit   mon_en       = 1'b0;
    bit   prev_hold    = 1'b0;
    logic [7:0] prev_outp = 8'h00;

    mod_reg16_ser_if #(.NBYTES(16), .BYTE_W(8)) if0 ();
    mod_reg16_ser_if #(.NBYTES(16), .BYTE_W(8)) if1 ();

    assign if0.inp        = inp;
    assign if0.load       = load;
    assign if0.fifo_empty = fifo_empty;
    assign if1.inp        = inp;
    assign if1.load       = load;
    assign if1.fifo_empty = fifo_empty;

    mod_reg16_ser #(.NBYTES(16), .BYTE_W(8), .MSB_FIRST(1)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    mod_reg16_ser #(.NBYTES(16), .BYTE_W(8), .MSB_FIRST(0)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    logic [7:0] obs_outp;
    logic       obs_empty, obs_ready, obs_last, obs_err;
    logic [3:0] obs_idx;

    assign obs_outp  = sel ? if1.outp     : if0.outp;
    assign obs_empty = sel ? if1.empty    : if0.empty;
    assign obs_ready = sel ? if1.ready_in : if0.ready_in;
    assign obs_last  = sel ? if1.last     : if0.last;
    assign obs_idx   = sel ? if1.byte_idx : if0.byte_idx;
    assign obs_err   = sel ? if1.load_err : if0.load_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one load request and, if it should be accepted, queues the 16 bytes it must produce
    task automatic applyStimulus(input logic [127:0] word, input bit accept);
        exp_t e;
        inp  = word;
        load = 1'b1;
        if (accept) begin
            for (int k = 0; k < 16; k++) begin
                e.data = sel ? word[k*8 +: 8] : word[(16-k)*8-1 -: 8];
                e.last = (k == 15);
                e.idx  = 4'(k);
                sb.push_back(e);
            end
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic waitDrain(input int budget, output int cycles);
        cycles = 0;
        while (sb.size() > 0 && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (sb.size() > 0) begin
            checkOutput("drain_timeout_left", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic waitIdx(input logic [3:0] target, input int budget);
        int n = 0;
        while (!(obs_idx == target && !obs_empty) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) checkOutput("wait_idx_timeout", obs_idx, target);
    endtask

    // Scoreboard: every edge that will transfer a byte must carry the next expected byte
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (!obs_empty && fifo_empty) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("outp", obs_outp, e.data);
                    checkOutput("last", obs_last, e.last);
                    checkOutput("byte_idx", obs_idx, e.idx);
                end
                xfer_pending = 1'b1;
            end
            if (prev_hold && !fifo_empty && !obs_empty)
                checkOutput("outp_stable", obs_outp, prev_outp);
            prev_hold = !fifo_empty && !obs_empty;
            prev_outp = obs_outp;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // One-byte FIFO model: fills on a transfer, drained by a ROM read every rd_period cycles
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rd_period != 0) begin
            if (fifo_full && (cyc % rd_period) == 0) fifo_full = 1'b0;
            else if (xfer_pending)                   fifo_full = 1'b1;
        end
        xfer_pending = 1'b0;
        fifo_empty   = !fifo_full;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset      = 1'b1;
        load       = 1'b0;
        inp        = '0;
        sel        = 1'b0;
        fifo_empty = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_empty", obs_empty, 1);
        checkOutput("rst_ready_in", obs_ready, 1);
        checkOutput("rst_outp", obs_outp, 8'h00);
        checkOutput("rst_byte_idx", obs_idx, 0);
        checkOutput("rst_load_err", obs_err, 0);
        checkOutput("rst_last", obs_last, 0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Basic MSB-first serialization with the FIFO always ready
        applyStimulus(128'h000102030405060708090A0B0C0D0E0F, 1'b1);
        stepCycle();
        waitDrain(40, n);
        checkOutput("basic_drain_cycles", n, 16);
        @(negedge clk);
        checkOutput("basic_done_empty", obs_empty, 1);
        checkOutput("basic_done_ready_in", obs_ready, 1);
        @(posedge clk);
        #1;

        // FIFO backpressure: ROM reads every third cycle
        rd_period = 3;
        applyStimulus(128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b1);
        stepCycle();
        waitDrain(200, n);
        repeat (4) @(posedge clk);
        #1;
        rd_period  = 0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b1;
        @(posedge clk);
        #1;

        // Illegal load while byte 5 is on the output
        applyStimulus(128'h00112233445566778899AABBCCDDEEFF, 1'b1);
        stepCycle();
        waitIdx(4'd5, 40);
        applyStimulus({128{1'b1}}, 1'b0);
        stepCycle();
        @(negedge clk);
        checkOutput("illegal_load_err_pulse", obs_err, 1);
        checkOutput("illegal_ready_in", obs_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("illegal_load_err_clear", obs_err, 0);
        waitDrain(40, n);
        @(posedge clk);
        #1;

        // Reset in the middle of a word
        applyStimulus(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 1'b1);
        stepCycle();
        waitIdx(4'd7, 40);
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst_empty", obs_empty, 1);
        checkOutput("midrst_ready_in", obs_ready, 1);
        checkOutput("midrst_byte_idx", obs_idx, 0);
        checkOutput("midrst_outp", obs_outp, 8'h00);
        checkOutput("midrst_last", obs_last, 0);
        @(posedge clk);
        #1;
        applyStimulus(128'h5A5B5C5D5E5F50515253545556575859, 1'b1);
        stepCycle();
        waitDrain(40, n);
        @(posedge clk);
        #1;

        // Back-to-back words on the LSB-first instance
        sel = 1'b1;
        applyStimulus(128'h0F0E0D0C0B0A09080706050403020100, 1'b1);
        stepCycle();
        n = 0;
        while (!obs_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("b2b_a_cycles", n, 16);
        applyStimulus(128'h8899AABBCCDDEEFF0011223344556677, 1'b1);
        @(negedge clk);
        checkOutput("b2b_idle_empty", obs_empty, 1);
        stepCycle();
        @(negedge clk);
        checkOutput("b2b_b_first_empty", obs_empty, 0);
        waitDrain(40, n);
        @(negedge clk);
        checkOutput("b2b_done_empty", obs_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
